// File: rtl/tri_span_sched.sv
// Per-scanline span scheduler: scans triangle slots in priority order and streams hits.
// Optional clipping against X_MAX is enabled by defining SPAN_CLIP_EN.
`timescale 1ns/1ps
module tri_span_sched #(
  parameter int unsigned N_TRI = 64,
  parameter int unsigned XW    = 8,
  parameter int unsigned IDXW  = 6,
  parameter int unsigned X_MAX = 159
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                line_start_i,
  input  logic [XW-1:0]       line_y_i,
  input  logic [N_TRI-1:0]    tri_en_i,
  input  logic [N_TRI*XW-1:0] tri_y_i,
  input  logic [N_TRI*XW-1:0] tri_xs_i,
  input  logic [N_TRI*XW-1:0] tri_xe_i,
  output logic                span_valid_o,
  input  logic                span_ready_i,
  output logic [IDXW-1:0]     span_idx_o,
  output logic [XW-1:0]       span_xs_o,
  output logic [XW-1:0]       span_xe_o,
  output logic                busy_o,
  output logic                line_done_o,
  output logic [IDXW:0]       span_cnt_o,
  output logic                overrun_o
);

`ifdef SPAN_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [XW-1:0]   X_LIM = XW'(X_MAX);
  localparam logic [IDXW-1:0] LAST  = IDXW'(N_TRI - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [XW-1:0]     y_q, y_d;
  logic [IDXW:0]     cnt_q, cnt_d;
  logic              span_valid_q, span_valid_d;
  logic [IDXW-1:0]   span_idx_q, span_idx_d;
  logic [XW-1:0]     span_xs_q, span_xs_d;
  logic [XW-1:0]     span_xe_q, span_xe_d;
  logic              line_done_q, line_done_d;
  logic [IDXW:0]     span_cnt_q, span_cnt_d;
  logic              overrun_q, overrun_d;

  logic [XW-1:0]     cur_y, cur_xs, cur_xe, out_xe;
  logic              hit, free;

  always_comb begin
    cur_y  = tri_y_i[idx_q*XW +: XW];
    cur_xs = tri_xs_i[idx_q*XW +: XW];
    cur_xe = tri_xe_i[idx_q*XW +: XW];
    hit    = tri_en_i[idx_q] && (cur_y == y_q) && (cur_xs <= cur_xe) &&
             (!CLIP_EN || (cur_xs <= X_LIM));
    out_xe = (CLIP_EN && (cur_xe > X_LIM)) ? X_LIM : cur_xe;
    // Output slot is reusable in the same cycle its current span is accepted.
    free   = !span_valid_q || span_ready_i;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    span_valid_d = span_valid_q && !span_ready_i;
    span_idx_d   = span_idx_q;
    span_xs_d    = span_xs_q;
    span_xe_d    = span_xe_q;
    line_done_d  = 1'b0;
    span_cnt_d   = span_cnt_q;
    overrun_d    = overrun_q;

    // The done-pulse cycle still counts as busy for a new line start.
    if (line_start_i && ((state_q != IDLE) || line_done_q))
      overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (line_start_i && !line_done_q) begin
          y_d     = line_y_i;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (free) begin
          if (hit) begin
            span_valid_d = 1'b1;
            span_idx_d   = idx_q;
            span_xs_d    = cur_xs;
            span_xe_d    = out_xe;
            cnt_d        = cnt_q + 1'b1;
          end
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (free) begin
          line_done_d = 1'b1;
          span_cnt_d  = cnt_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      span_valid_q <= 1'b0;
      span_idx_q   <= '0;
      span_xs_q    <= '0;
      span_xe_q    <= '0;
      line_done_q  <= 1'b0;
      span_cnt_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      span_valid_q <= span_valid_d;
      span_idx_q   <= span_idx_d;
      span_xs_q    <= span_xs_d;
      span_xe_q    <= span_xe_d;
      line_done_q  <= line_done_d;
      span_cnt_q   <= span_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  assign span_valid_o = span_valid_q;
  assign span_idx_o   = span_idx_q;
  assign span_xs_o    = span_xs_q;
  assign span_xe_o    = span_xe_q;
  assign busy_o       = (state_q != IDLE);
  assign line_done_o  = line_done_q;
  assign span_cnt_o   = span_cnt_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_tri_span_sched.sv
// Bench for tri_span_sched: a per-line span model plus directed scanline scenarios.
`timescale 1ns/1ps
module tb_tri_span_sched;
  localparam int N  = 64;
  localparam int XW = 8;
  localparam int IW = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ls  = 1'b0;
  logic [XW-1:0]   ly  = '0;
  logic            rdy = 1'b1;
  logic [N-1:0]    en  = '0;
  logic [XW-1:0]   ty [N];
  logic [XW-1:0]   txs[N];
  logic [XW-1:0]   txe[N];
  logic [N*XW-1:0] ty_bus, txs_bus, txe_bus;

  logic            span_valid, busy, line_done, overrun;
  logic [IW-1:0]   span_idx;
  logic [XW-1:0]   span_xs, span_xe;
  logic [IW:0]     span_cnt;

  always_comb begin
    ty_bus  = '0;
    txs_bus = '0;
    txe_bus = '0;
    for (int i = 0; i < N; i++) begin
      ty_bus[i*XW +: XW]  = ty[i];
      txs_bus[i*XW +: XW] = txs[i];
      txe_bus[i*XW +: XW] = txe[i];
    end
  end

  tri_span_sched #(.N_TRI(N), .XW(XW), .IDXW(IW), .X_MAX(159)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .line_start_i(ls),
    .line_y_i    (ly),
    .tri_en_i    (en),
    .tri_y_i     (ty_bus),
    .tri_xs_i    (txs_bus),
    .tri_xe_i    (txe_bus),
    .span_valid_o(span_valid),
    .span_ready_i(rdy),
    .span_idx_o  (span_idx),
    .span_xs_o   (span_xs),
    .span_xe_o   (span_xe),
    .busy_o      (busy),
    .line_done_o (line_done),
    .span_cnt_o  (span_cnt),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {int idx; int xs; int xe;} span_t;
  span_t exp_q[$];
  span_t got_q[$];

  int tests = 0;
  int fails = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  // Reference: every enabled slot on this row with a non-empty span, in slot order.
  function automatic void build_model(input logic [XW-1:0] y);
    span_t s;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (en[i] && ty[i] == y && txs[i] <= txe[i]) begin
        s.idx = i;
        s.xs  = int'(txs[i]);
        s.xe  = int'(txe[i]);
`ifdef SPAN_CLIP_EN
        if (txs[i] > 8'd159) continue;
        if (s.xe > 159) s.xe = 159;
`endif
        exp_q.push_back(s);
      end
    end
  endfunction

  bit          active, start_pend, prev_stall;
  int unsigned start_edge;
  int          stalls, last_stalls, last_cycle, exp_cnt, done_cnt;
  logic [IW-1:0] p_idx;
  logic [XW-1:0] p_xs, p_xe;

  initial begin
    active = 0; start_pend = 0; prev_stall = 0;
    stalls = 0; last_stalls = 0; last_cycle = 0; exp_cnt = 0; done_cnt = 0;
    start_edge = 0;
  end

  always @(negedge clk) begin
    span_t e, g;
    if (rst) begin
      active = 0; start_pend = 0; prev_stall = 0;
      exp_q.delete();
    end else begin
      if (start_pend) begin
        active = 1;
        start_pend = 0;
      end
      if (prev_stall) begin
        chk("hold_valid", span_valid, 1);
        chk("hold_idx", span_idx, p_idx);
        chk("hold_xs", span_xs, p_xs);
        chk("hold_xe", span_xe, p_xe);
      end
      if (active && span_valid && !rdy) stalls++;
      if (span_valid && rdy) begin
        g.idx = int'(span_idx); g.xs = int'(span_xs); g.xe = int'(span_xe);
        got_q.push_back(g);
        if (exp_q.size() == 0) chk("extra_span", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("span_idx", span_idx, e.idx);
          chk("span_xs", span_xs, e.xs);
          chk("span_xe", span_xe, e.xe);
        end
      end
      if (line_done) begin
        done_cnt++;
        chk("done_in_line", active, 1);
        last_cycle  = int'(edge_n - start_edge) + 1;
        last_stalls = stalls;
        chk("done_cycle", last_cycle, N + 2 + stalls);
        chk("span_cnt", span_cnt, exp_cnt);
        chk("spans_left", exp_q.size(), 0);
        active = 0;
      end
      chk("busy", busy, active);
      if (ls && !busy && !line_done) begin
        build_model(ly);
        exp_cnt    = exp_q.size();
        start_edge = edge_n + 1;
        stalls     = 0;
        start_pend = 1;
      end
      prev_stall = span_valid && !rdy;
      p_idx = span_idx; p_xs = span_xs; p_xe = span_xe;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [XW-1:0] y);
    @(posedge clk); #1;
    ly = y; ls = 1'b1;
    @(posedge clk); #1;
    ls = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    bit seen = 0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(negedge clk);
      seen = line_done;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int maxc);
    bit seen = 0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(negedge clk);
      seen = span_valid;
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask

  task automatic clear_tris();
    en = '0;
    for (int i = 0; i < N; i++) begin
      ty[i] = '0; txs[i] = '0; txe[i] = '0;
    end
    got_q.delete();
  endtask

  task automatic set_slot(input int i, input logic [XW-1:0] y, input logic [XW-1:0] xs,
                          input logic [XW-1:0] xe);
    en[i] = 1'b1; ty[i] = y; txs[i] = xs; txe[i] = xe;
  endtask

  task automatic chk_got(input string nm, input int k, input int idx, input int xs, input int xe);
    if (got_q.size() <= k) chk({nm, "_missing"}, got_q.size(), k + 1);
    else begin
      chk({nm, "_idx"}, got_q[k].idx, idx);
      chk({nm, "_xs"}, got_q[k].xs, xs);
      chk({nm, "_xe"}, got_q[k].xe, xe);
    end
  endtask

  task automatic setup_t2();
    clear_tris();
    set_slot(3, 8'd10, 8'd5, 8'd20);
    set_slot(60, 8'd10, 8'd30, 8'd40);
  endtask

  initial begin
    int d0;
    clear_tris();
    tick(3);
    chk("rst_valid", span_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", line_done, 0);
    chk("rst_cnt", span_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_idx", span_idx, 0);
    chk("rst_xs", span_xs, 0);
    chk("rst_xe", span_xe, 0);
    rst = 1'b0;
    tick(2);

    // T1: nothing enabled
    clear_tris();
    start_line(8'd10);
    wait_done(200);
    chk("t1_cycle", last_cycle, 66);
    chk("t1_cnt", span_cnt, 0);
    chk("t1_spans", got_q.size(), 0);

    // T2: two hits, ready high
    setup_t2();
    start_line(8'd10);
    wait_done(200);
    chk("t2_nspans", got_q.size(), 2);
    chk_got("t2_a", 0, 3, 5, 20);
    chk_got("t2_b", 1, 60, 30, 40);
    chk("t2_cnt", span_cnt, 2);
    chk("t2_cycle", last_cycle, 66);

    // Boundary slots and a single-pixel span
    clear_tris();
    set_slot(0, 8'd10, 8'd9, 8'd9);
    set_slot(63, 8'd10, 8'd9, 8'd9);
    start_line(8'd10);
    wait_done(200);
    chk_got("edge_a", 0, 0, 9, 9);
    chk_got("edge_b", 1, 63, 9, 9);
    chk("edge_cnt", span_cnt, 2);
    chk("edge_cycle", last_cycle, 66);

    // T3: 10-cycle stall on the first span
    setup_t2();
    rdy = 1'b0;
    start_line(8'd10);
    wait_valid(100);
    repeat (9) @(negedge clk);
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_done(300);
    chk("t3_stalls", last_stalls, 10);
    chk("t3_cycle", last_cycle, 76);
    chk_got("t3_a", 0, 3, 5, 20);
    chk_got("t3_b", 1, 60, 30, 40);
    chk("t3_cnt", span_cnt, 2);

    // T4: inverted span and wrong row both rejected
    clear_tris();
    set_slot(7, 8'd10, 8'd50, 8'd40);
    set_slot(8, 8'd11, 8'd0, 8'd5);
    start_line(8'd10);
    wait_done(200);
    chk("t4_spans", got_q.size(), 0);
    chk("t4_cnt", span_cnt, 0);

    // Every slot hits: count reaches N
    clear_tris();
    en = '1;
    for (int i = 0; i < N; i++) begin
      ty[i] = 8'd10; txs[i] = 8'(i); txe[i] = 8'(i + 2);
    end
    start_line(8'd10);
    wait_done(300);
    chk("all_cnt", span_cnt, 64);
    chk("all_spans", got_q.size(), 64);
    chk("all_cycle", last_cycle, 66);

    // T5: line start while busy
    setup_t2();
    d0 = done_cnt;
    start_line(8'd10);
    tick(3);
    ly = 8'd11; ls = 1'b1;
    @(posedge clk); #1;
    ls = 1'b0;
    chk("t5_overrun", overrun, 1);
    wait_done(200);
    tick(80);
    chk("t5_dones", done_cnt - d0, 1);
    chk("t5_spans", got_q.size(), 2);
    chk("t5_overrun_sticky", overrun, 1);

    // Reset mid-scan with a span pending
    setup_t2();
    rdy = 1'b0;
    start_line(8'd10);
    wait_valid(100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", span_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    rst = 1'b0;
    rdy = 1'b1;
    tick(2);

    // Line start during the done pulse is ignored and flagged
    clear_tris();
    d0 = done_cnt;
    start_line(8'd10);
    begin
      bit seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge clk);
        seen = line_done;
      end
      if (!seen) chk("dc_timeout", 0, 1);
    end
    ls = 1'b1;
    @(posedge clk); #1;
    ls = 1'b0;
    chk("dc_busy", busy, 0);
    chk("dc_overrun", overrun, 1);
    tick(80);
    chk("dc_dones", done_cnt - d0, 1);

`ifdef SPAN_CLIP_EN
    // T6: clipping against X_MAX
    clear_tris();
    set_slot(0, 8'd10, 8'd150, 8'd200);
    set_slot(1, 8'd10, 8'd170, 8'd180);
    start_line(8'd10);
    wait_done(200);
    chk("t6_spans", got_q.size(), 1);
    chk_got("t6_a", 0, 0, 150, 159);
    chk("t6_cnt", span_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
